alu_result_stage: RTL and testbench
===================================

# alu_result_stage

Registered stage directly downstream of the ArithmeticLogicUnit. It captures each ALU result (ALUOut plus a destination tag) into a small FIFO for write-back to the register file. It holds the architectural flag register {Z,C,N,O}, loaded from FlagsOut when WF is set. It evaluates branch condition codes against the registered flags for the control unit.

## Interface
Parameters:
- DEPTH, 4, result FIFO entries; power of two, ≥2
- TAG_W, 3, width of destination-register tag

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- ALUOut  in  32  result from ALU
- FlagsOut  in  4  ALU flags, [3]=Z [2]=C [1]=N [0]=O
- WF  in  1  write-flags enable accompanying the input
- InValid  in  1  ALUOut/DstTag valid this cycle
- DstTag  in  TAG_W  destination register of the result
- InReady  out  1  stage can accept (FIFO not full)
- OutValid  out  1  head entry valid (FIFO not empty)
- OutReady  in  1  register file consumes head this cycle
- OutData  out  32  head result
- OutTag  out  TAG_W  head destination tag
- Count  out  $clog2(DEPTH)+1  current occupancy
- FlagLoad  in  1  overwrite flag register (context restore)
- FlagIn  in  4  value for FlagLoad
- Flags  out  4  flag register, same bit order as FlagsOut
- CondCode  in  4  condition selector
- CondTrue  out  1  condition result on Flags

## Operation
- Push = InValid & InReady. Pop = OutValid & OutReady. InReady = (Count != DEPTH).
- Push writes {ALUOut, DstTag} at the write pointer. Pop advances the read pointer. Pointers wrap modulo DEPTH.
- Push and pop may occur in the same cycle. Count is then unchanged. This is legal when empty only if an entry was already present, i.e. OutValid was 1. No same-cycle bypass: an empty FIFO gives OutValid=0 even when InValid=1.
- When full, InReady=0 and InValid is ignored. Upstream holds its data. The full-with-pop case does not accept the same cycle.
- Pop while empty is a no-op. OutData/OutTag are don't-care when OutValid=0.
- Flag register update priority:
  1. FlagLoad: Flags ← FlagIn.
  2. Otherwise, Push & WF: Flags ← FlagsOut.
  3. Otherwise, hold.
- Flags update only on an accepted push. A stalled input (InReady=0) never changes Flags.
- WF with InValid=0 does nothing.
- CondCode → CondTrue, combinational on registered Flags:
  - 0 always
  - 1 Z
  - 2 !Z
  - 3 C
  - 4 !C
  - 5 N
  - 6 !N
  - 7 O
  - 8 !O
  - 9 C&!Z
  - 10 !C|Z
  - 11 N==O
  - 12 N!=O
  - 13 !Z&(N==O)
  - 14 Z|(N!=O)
  - 15 never

## Timing
- Reset:
  - Count=0, OutValid=0, InReady=1, Flags=4'b0000, pointers=0.
  - OutData/OutTag read as 0 after reset. Storage is cleared or the output is masked.
  - Reset mid-operation discards all entries and pending flags that same edge.
- Latency from push to OutValid: 1 cycle.
- Latency from an accepted WF push or FlagLoad to Flags: 1 cycle.
- CondTrue reflects Flags of the current cycle. It does not see a same-cycle FlagsOut.
- Throughput: one push and one pop per cycle sustained.
- InReady and OutValid are functions of registered Count only. There is no combinational path from OutReady to InReady.

## Structure
- Package alu_pkg:
  - flag bit index constants FLAG_Z=3, FLAG_C=2, FLAG_N=1, FLAG_O=0
  - 4-bit condition-code constants COND_AL … COND_NV
  - flags typedef
- Sub-module result_fifo (parameterised DEPTH, data width):
  - storage, pointers, Count, full/empty
- The top level holds the flag register and the condition decode.

## Test plan
- Reset, then one push with ALUOut=32'h1234_5678, DstTag=3'd5, WF=0 → next cycle OutValid=1, OutData=32'h1234_5678, OutTag=5; Flags stays 0000.
- Push with FlagsOut=4'b0100, WF=1 → Flags=4'b0100 next cycle; CondCode=3 gives CondTrue=1, CondCode=9 gives CondTrue=1, CondCode=1 gives CondTrue=0.
- Five pushes with OutReady=0 (DEPTH=4) → InReady=0 after four, Count=4, fifth value not stored, its WF flags not written. Then four pops return the values in order.
- Continuous push and pop with 1-cycle lag → Count stays at 1 and no data is lost across pointer wrap-around (≥10 values).
- FlagLoad=1, FlagIn=4'b1010 in the same cycle as a push with WF=1 and FlagsOut=4'b0001 → Flags=4'b1010. CondCode=13 gives CondTrue=0, CondCode=14 gives CondTrue=1.
- Assert Reset with 3 entries queued and Flags=4'b1111 → next cycle Count=0, OutValid=0, Flags=0000, InReady=1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: flag bit positions,
// branch condition codes and the condition evaluator.
package alu_pkg;

    localparam int FLAG_Z = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_O = 0;

    localparam logic [3:0] COND_AL = 4'd0;
    localparam logic [3:0] COND_EQ = 4'd1;
    localparam logic [3:0] COND_NE = 4'd2;
    localparam logic [3:0] COND_CS = 4'd3;
    localparam logic [3:0] COND_CC = 4'd4;
    localparam logic [3:0] COND_MI = 4'd5;
    localparam logic [3:0] COND_PL = 4'd6;
    localparam logic [3:0] COND_VS = 4'd7;
    localparam logic [3:0] COND_VC = 4'd8;
    localparam logic [3:0] COND_HI = 4'd9;
    localparam logic [3:0] COND_LS = 4'd10;
    localparam logic [3:0] COND_GE = 4'd11;
    localparam logic [3:0] COND_LT = 4'd12;
    localparam logic [3:0] COND_GT = 4'd13;
    localparam logic [3:0] COND_LE = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    // {Z,C,N,O}, Z in the MSB
    typedef logic [3:0] flags_t;

    function automatic logic cond_eval(input logic [3:0] cc, input flags_t f);
        logic z, c, n, o;
        logic res;
        z = f[FLAG_Z];
        c = f[FLAG_C];
        n = f[FLAG_N];
        o = f[FLAG_O];
        case (cc)
            COND_AL: res = 1'b1;
            COND_EQ: res = z;
            COND_NE: res = !z;
            COND_CS: res = c;
            COND_CC: res = !c;
            COND_MI: res = n;
            COND_PL: res = !n;
            COND_VS: res = o;
            COND_VC: res = !o;
            COND_HI: res = c & !z;
            COND_LS: res = !c | z;
            COND_GE: res = (n == o);
            COND_LT: res = (n != o);
            COND_GT: res = !z & (n == o);
            COND_LE: res = z | (n != o);
            default: res = 1'b0;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Small synchronous FIFO holding ALU results awaiting write-back.
// Ready/valid derive from the registered occupancy only, so there is no
// combinational path from the consumer's ready to the producer's ready.
module result_fifo #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 35
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     valid_i,
    input  logic [DATA_W-1:0]        data_i,
    output logic                     in_ready_o,
    output logic                     push_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DATA_W-1:0]        data_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    import alu_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              push, pop;

    // Handshake decode and next-state pointers/occupancy
    always_comb begin
        in_ready_o  = (count_q != FULL_CNT);
        out_valid_o = (count_q != '0);
        push        = valid_i & in_ready_o;
        pop         = out_valid_o & out_ready_i;
        wr_ptr_d    = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d     = count_q;
        if (push && !pop)
            count_d = count_q + CNT_W'(1);
        else if (pop && !push)
            count_d = count_q - CNT_W'(1);
    end

    // Storage and pointers; storage is cleared so the head reads 0 after reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push)
                mem_q[wr_ptr_q] <= data_i;
        end
    end

    assign push_o  = push;
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/alu_result_stage.sv
// Result stage after the ALU: queues results for register write-back,
// holds the architectural flag register and decodes branch conditions.
module alu_result_stage #(
    parameter int DEPTH = 4,
    parameter int TAG_W = 3
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic [31:0]             ALUOut,
    input  logic [3:0]              FlagsOut,
    input  logic                    WF,
    input  logic                    InValid,
    input  logic [TAG_W-1:0]        DstTag,
    output logic                    InReady,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic [31:0]             OutData,
    output logic [TAG_W-1:0]        OutTag,
    output logic [$clog2(DEPTH):0]  Count,
    input  logic                    FlagLoad,
    input  logic [3:0]              FlagIn,
    output logic [3:0]              Flags,
    input  logic [3:0]              CondCode,
    output logic                    CondTrue
);
    import alu_pkg::*;

    localparam int DATA_W = 32 + TAG_W;

    logic [DATA_W-1:0] head;
    logic              push;
    flags_t            flags_q, flags_d;

    result_fifo #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk_i       (Clock),
        .rst_i       (Reset),
        .valid_i     (InValid),
        .data_i      ({ALUOut, DstTag}),
        .in_ready_o  (InReady),
        .push_o      (push),
        .out_valid_o (OutValid),
        .out_ready_i (OutReady),
        .data_o      (head),
        .count_o     (Count)
    );

    assign OutData = head[DATA_W-1:TAG_W];
    assign OutTag  = head[TAG_W-1:0];

    // Flag source select: context restore wins over an accepted flag-writing push
    always_comb begin
        flags_d = flags_q;
        if (FlagLoad)
            flags_d = FlagIn;
        else if (push && WF)
            flags_d = FlagsOut;
    end

    // Architectural flag register
    always_ff @(posedge Clock) begin
        if (Reset)
            flags_q <= '0;
        else
            flags_q <= flags_d;
    end

    assign Flags    = flags_q;
    assign CondTrue = cond_eval(CondCode, flags_q);

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

    logic        Clock = 1'b0;
    logic        Reset;
    logic [31:0] ALUOut;
    logic [3:0]  FlagsOut;
    logic        WF;
    logic        InValid;
    logic [2:0]  DstTag;
    logic        InReady;
    logic        OutValid;
    logic        OutReady;
    logic [31:0] OutData;
    logic [2:0]  OutTag;
    logic [2:0]  Count;
    logic        FlagLoad;
    logic [3:0]  FlagIn;
    logic [3:0]  Flags;
    logic [3:0]  CondCode;
    logic        CondTrue;

    int passed = 0;
    int total  = 0;

    always #5 Clock = ~Clock;

    alu_result_stage #(.DEPTH(4), .TAG_W(3)) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .ALUOut   (ALUOut),
        .FlagsOut (FlagsOut),
        .WF       (WF),
        .InValid  (InValid),
        .DstTag   (DstTag),
        .InReady  (InReady),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutData  (OutData),
        .OutTag   (OutTag),
        .Count    (Count),
        .FlagLoad (FlagLoad),
        .FlagIn   (FlagIn),
        .Flags    (Flags),
        .CondCode (CondCode),
        .CondTrue (CondTrue)
    );

    typedef struct {
        logic [3:0] flg;
        logic [3:0] cc;
        logic       exp;
    } cond_vec_t;

    cond_vec_t vecs [24];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // advance one clock; inputs change 1 time unit after the edge
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        logic [31:0] stream [12];

        vecs[0]  = '{4'b0000, 4'd0,  1'b1};
        vecs[1]  = '{4'b0000, 4'd15, 1'b0};
        vecs[2]  = '{4'b0000, 4'd2,  1'b1};
        vecs[3]  = '{4'b0000, 4'd11, 1'b1};
        vecs[4]  = '{4'b0000, 4'd13, 1'b1};
        vecs[5]  = '{4'b0000, 4'd10, 1'b1};
        vecs[6]  = '{4'b1000, 4'd1,  1'b1};
        vecs[7]  = '{4'b1000, 4'd2,  1'b0};
        vecs[8]  = '{4'b1000, 4'd14, 1'b1};
        vecs[9]  = '{4'b1000, 4'd13, 1'b0};
        vecs[10] = '{4'b0010, 4'd5,  1'b1};
        vecs[11] = '{4'b0010, 4'd6,  1'b0};
        vecs[12] = '{4'b0010, 4'd12, 1'b1};
        vecs[13] = '{4'b0010, 4'd11, 1'b0};
        vecs[14] = '{4'b0010, 4'd14, 1'b1};
        vecs[15] = '{4'b0011, 4'd11, 1'b1};
        vecs[16] = '{4'b0011, 4'd12, 1'b0};
        vecs[17] = '{4'b0011, 4'd7,  1'b1};
        vecs[18] = '{4'b0011, 4'd8,  1'b0};
        vecs[19] = '{4'b0100, 4'd9,  1'b1};
        vecs[20] = '{4'b0100, 4'd10, 1'b0};
        vecs[21] = '{4'b0100, 4'd4,  1'b0};
        vecs[22] = '{4'b1100, 4'd9,  1'b0};
        vecs[23] = '{4'b1111, 4'd3,  1'b1};

        Reset = 1'b1; ALUOut = '0; FlagsOut = '0; WF = 1'b0; InValid = 1'b0;
        DstTag = '0; OutReady = 1'b0; FlagLoad = 1'b0; FlagIn = '0; CondCode = '0;
        tick(); tick();
        Reset = 1'b0;
        #1;
        chk("rst_count", 32'(Count), 0);
        chk("rst_outvalid", 32'(OutValid), 0);
        chk("rst_inready", 32'(InReady), 1);
        chk("rst_flags", 32'(Flags), 0);
        chk("rst_outdata", OutData, 0);
        chk("rst_outtag", 32'(OutTag), 0);

        // single push, WF=0 so FlagsOut must be ignored
        InValid = 1'b1; ALUOut = 32'h1234_5678; DstTag = 3'd5; FlagsOut = 4'b1111; WF = 1'b0;
        #1;
        chk("no_bypass_outvalid", 32'(OutValid), 0);
        tick();
        InValid = 1'b0;
        #1;
        chk("p1_outvalid", 32'(OutValid), 1);
        chk("p1_outdata", OutData, 32'h1234_5678);
        chk("p1_outtag", 32'(OutTag), 5);
        chk("p1_flags", 32'(Flags), 0);
        chk("p1_count", 32'(Count), 1);
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;
        #1;
        chk("p1_drained", 32'(Count), 0);

        // WF with InValid=0 does nothing
        WF = 1'b1; FlagsOut = 4'b1010;
        tick();
        WF = 1'b0;
        #1;
        chk("wf_no_valid_flags", 32'(Flags), 0);

        // push with WF=1
        InValid = 1'b1; ALUOut = 32'hCAFE_0001; DstTag = 3'd2; FlagsOut = 4'b0100; WF = 1'b1;
        tick();
        InValid = 1'b0; WF = 1'b0;
        #1;
        chk("p2_flags", 32'(Flags), 4'b0100);
        CondCode = 4'd3; #1; chk("p2_cc3", 32'(CondTrue), 1);
        CondCode = 4'd9; #1; chk("p2_cc9", 32'(CondTrue), 1);
        CondCode = 4'd1; #1; chk("p2_cc1", 32'(CondTrue), 0);
        OutReady = 1'b1;
        tick();
        OutReady = 1'b0;

        // condition table via FlagLoad
        for (int i = 0; i < 24; i++) begin
            FlagLoad = 1'b1; FlagIn = vecs[i].flg;
            tick();
            FlagLoad = 1'b0;
            CondCode = vecs[i].cc;
            #1;
            chk($sformatf("vec%0d_flags", i), 32'(Flags), 32'(vecs[i].flg));
            chk($sformatf("vec%0d_cond", i), 32'(CondTrue), 32'(vecs[i].exp));
        end

        // fill to full with OutReady=0, fifth push must be refused
        FlagLoad = 1'b1; FlagIn = 4'b0000;
        tick();
        FlagLoad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            InValid = 1'b1; ALUOut = 32'hA000_0000 + 32'(i); DstTag = 3'(i + 1);
            WF = 1'b1; FlagsOut = 4'b0001;
            tick();
            chk($sformatf("fill%0d_inready", i), 32'(InReady), (i == 3) ? 0 : 1);
        end
        ALUOut = 32'hA000_0004; DstTag = 3'd7; FlagsOut = 4'b1000; WF = 1'b1;
        tick();
        InValid = 1'b0; WF = 1'b0;
        #1;
        chk("full_count", 32'(Count), 4);
        chk("full_flags_kept", 32'(Flags), 4'b0001);
        chk("full_inready", 32'(InReady), 0);
        OutReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("drain%0d_data", i), OutData, 32'hA000_0000 + 32'(i));
            chk($sformatf("drain%0d_tag", i), 32'(OutTag), 32'(i + 1));
            tick();
        end
        OutReady = 1'b0;
        #1;
        chk("drain_empty", 32'(OutValid), 0);

        // streaming push/pop with one-cycle lag across pointer wrap
        for (int i = 0; i < 12; i++)
            stream[i] = 32'h5500_0000 + 32'(i * 17);
        InValid = 1'b1; ALUOut = stream[0]; DstTag = 3'd0;
        tick();
        for (int k = 1; k < 12; k++) begin
            chk($sformatf("stream%0d_count", k), 32'(Count), 1);
            chk($sformatf("stream%0d_data", k), OutData, stream[k-1]);
            ALUOut = stream[k]; DstTag = 3'(k); OutReady = 1'b1;
            tick();
        end
        InValid = 1'b0;
        chk("stream_last_data", OutData, stream[11]);
        chk("stream_last_tag", 32'(OutTag), 3);
        tick();
        OutReady = 1'b0;
        #1;
        chk("stream_empty", 32'(Count), 0);

        // FlagLoad overrides a same-cycle WF push
        InValid = 1'b1; ALUOut = 32'h0000_0BEE; DstTag = 3'd1; WF = 1'b1; FlagsOut = 4'b0001;
        FlagLoad = 1'b1; FlagIn = 4'b1010;
        tick();
        InValid = 1'b0; WF = 1'b0; FlagLoad = 1'b0;
        #1;
        chk("prio_flags", 32'(Flags), 4'b1010);
        CondCode = 4'd13; #1; chk("prio_cc13", 32'(CondTrue), 0);
        CondCode = 4'd14; #1; chk("prio_cc14", 32'(CondTrue), 1);
        chk("prio_count", 32'(Count), 1);

        // queue three entries with Flags=1111, then reset with activity pending
        InValid = 1'b1; ALUOut = 32'h1; tick();
        ALUOut = 32'h2; FlagLoad = 1'b1; FlagIn = 4'b1111; tick();
        InValid = 1'b0; FlagLoad = 1'b0;
        #1;
        chk("pre_rst_count", 32'(Count), 3);
        chk("pre_rst_flags", 32'(Flags), 4'b1111);
        Reset = 1'b1; InValid = 1'b1; WF = 1'b1; FlagsOut = 4'b0101;
        FlagLoad = 1'b1; FlagIn = 4'b0110;
        tick();
        Reset = 1'b0; InValid = 1'b0; WF = 1'b0; FlagLoad = 1'b0;
        #1;
        chk("mid_rst_count", 32'(Count), 0);
        chk("mid_rst_outvalid", 32'(OutValid), 0);
        chk("mid_rst_flags", 32'(Flags), 0);
        chk("mid_rst_inready", 32'(InReady), 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
